// File: rtl/cpu_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues reads to the synchronous
// instruction memory, buffers returned instructions with their PCs in a small
// prefetch FIFO and hands them to decode over a valid/ready handshake.
//
// Handshake (decode side): id_valid is high whenever the FIFO holds an entry;
// a transfer happens on every cycle where id_valid && id_ready, and the head is
// popped at that clock edge. While id_valid=1 and id_ready=0 the head
// (id_instr/id_pc) stays stable unless a redirect flushes the FIFO.
module cpu_fetch_unit #(
    parameter int IW    = 19,
    parameter int AW    = 10,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_rdata,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_addr,
    output logic          id_valid,
    output logic [IW-1:0] id_instr,
    output logic [AW-1:0] id_pc,
    input  logic          id_ready
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] fetch_pc;
    logic          inflight;
    logic [AW-1:0] inflight_pc;

    logic [IW-1:0] fifo_instr [DEPTH];
    logic [AW-1:0] fifo_pc    [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    logic [PW+1:0] credit_used;
    logic          push;
    logic          pop;

    // Credit accounting and handshake decode. A request is only issued when
    // the FIFO is guaranteed to have room for its response one cycle later.
    always_comb begin
        credit_used = {1'b0, count} + {{(PW+1){1'b0}}, inflight};
        imem_req    = !reset && !redirect_valid && (credit_used < (PW+2)'(DEPTH));
        imem_addr   = fetch_pc;
        // A response arriving in a redirect cycle belongs to the wrong path.
        push        = inflight && !redirect_valid;
        id_valid    = (count != '0);
        pop         = id_valid && id_ready;
        id_instr    = fifo_instr[rd_ptr];
        id_pc       = fifo_pc[rd_ptr];
    end

    // Fetch PC and outstanding-request tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= imem_req;
            if (redirect_valid) begin
                fetch_pc <= redirect_addr;
            end else if (imem_req) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + AW'(1);
            end
        end
    end

    // FIFO pointers and occupancy; a redirect discards everything still queued
    // (a head popped in the same cycle has already been taken by decode).
    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; cleared on reset so the head never shows X.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else if (push) begin
            fifo_instr[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]    <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Bench for cpu_fetch_unit: synchronous memory model with mem[i]=i+0x100,
// expected {pc,instr} queue filled when the fetch stream is started or
// redirected, and drained by a monitor on every accepted transfer.
module tb_cpu_fetch_unit;
  localparam int IW = 19;
  localparam int AW = 10;
  localparam int DEPTH = 4;

  logic          clk;
  logic          reset;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic          id_valid;
  logic [IW-1:0] id_instr;
  logic [AW-1:0] id_pc;
  logic          id_ready;

  cpu_fetch_unit #(.IW(IW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_ready       (id_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory model: one-cycle read latency
  logic [IW-1:0] mem [1024];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = IW'(i + 'h100);
    imem_rdata = '0;
  end
  always @(posedge clk) if (imem_req) imem_rdata <= mem[imem_addr];

  // scoreboard state
  logic [AW+IW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int xfer_cnt = 0;
  int x0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // expected fetch stream starting at a PC, wrapping modulo 2^AW
  task automatic load_seq(input logic [AW-1:0] start, input int n);
    logic [AW-1:0] pc;
    logic [IW-1:0] ins;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      pc  = start + AW'(k);
      ins = {{(IW-AW){1'b0}}, pc} + IW'('h100);
      exp_q.push_back({pc, ins});
    end
  endtask

  // monitor: every accepted transfer must match the queue head
  always @(negedge clk) begin
    if (!reset && id_valid && id_ready) begin
      xfer_cnt++;
      if (exp_q.size() == 0) check_eq("xfer_unexpected", 32'(exp_q.size()), 32'd1);
      else check_eq("xfer", {id_pc, id_instr}, exp_q.pop_front());
    end
  end

  initial begin
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr = '0;
    id_ready = 1'b1;

    // reset state
    step();
    check_eq("rst_req", imem_req, 0);
    step();
    check_eq("rst_valid", id_valid, 0);
    check_eq("rst_instr", id_instr, 0);
    check_eq("rst_pc", id_pc, 0);
    check_eq("rst_addr", imem_addr, 0);

    // sequential fetch
    reset = 1'b0;
    load_seq(0, 40);
    #1;
    check_eq("first_req", imem_req, 1);
    check_eq("first_addr", imem_addr, 0);
    step();
    check_eq("lat_c1_valid", id_valid, 0);
    step();
    check_eq("lat_c2_valid", id_valid, 1);
    check_eq("lat_c2_pc", id_pc, 0);
    x0 = xfer_cnt;
    repeat (9) begin
      step();
      check_eq("no_gap", id_valid, 1);
    end
    step();
    check_eq("seq_xfers", 32'(xfer_cnt - x0), 10);

    // backpressure from a fresh reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    id_ready = 1'b0;
    load_seq(0, 40);
    #1;
    check_eq("bp_req0", imem_req, 1);
    step();
    step();
    check_eq("bp_valid", id_valid, 1);
    repeat (10) begin
      step();
      check_eq("bp_hold_pc", id_pc, 0);
      check_eq("bp_hold_instr", id_instr, 'h100);
    end
    check_eq("bp_credit_req", imem_req, 0);
    check_eq("bp_credit_addr", imem_addr, DEPTH);
    x0 = xfer_cnt;
    id_ready = 1'b1;
    repeat (5) step();
    id_ready = 1'b0;
    step();
    step();
    check_eq("bp_xfers", 32'(xfer_cnt - x0), 5);
    check_eq("bp_head_pc", id_pc, 5);
    check_eq("bp_full_req", imem_req, 0);

    // redirect while FIFO holds 5..8
    redirect_valid = 1'b1;
    redirect_addr = 10'h200;
    #1;
    check_eq("rdx_req_low", imem_req, 0);
    step();
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    load_seq(10'h200, 16);
    #1;
    check_eq("rdx_req", imem_req, 1);
    check_eq("rdx_addr", imem_addr, 'h200);
    check_eq("rdx_n1_valid", id_valid, 0);
    step();
    check_eq("rdx_n2_valid", id_valid, 0);
    step();
    check_eq("rdx_n3_valid", id_valid, 1);
    check_eq("rdx_n3_pc", id_pc, 'h200);
    repeat (4) step();

    // redirect with simultaneous transfer at pc 7
    redirect_valid = 1'b1;
    redirect_addr = 10'h005;
    step();
    redirect_valid = 1'b0;
    load_seq(10'h005, 16);
    step();
    step();
    check_eq("rxt_pc5", id_pc, 5);
    step();
    step();
    check_eq("rxt_pc7", id_pc, 7);
    check_eq("rxt_valid7", id_valid, 1);
    x0 = xfer_cnt;
    redirect_valid = 1'b1;
    redirect_addr = 10'h010;
    step();
    redirect_valid = 1'b0;
    check_eq("rxt_consumed", 32'(xfer_cnt - x0), 1);
    load_seq(10'h010, 16);
    check_eq("rxt_n1_valid", id_valid, 0);
    step();
    check_eq("rxt_n2_valid", id_valid, 0);
    step();
    check_eq("rxt_n3_valid", id_valid, 1);
    check_eq("rxt_n3_pc", id_pc, 'h010);
    repeat (3) step();

    // address wrap-around
    redirect_valid = 1'b1;
    redirect_addr = 10'h3FE;
    step();
    redirect_valid = 1'b0;
    load_seq(10'h3FE, 16);
    step();
    step();
    check_eq("wrap_3fe", id_pc, 'h3FE);
    step();
    step();
    check_eq("wrap_000", id_pc, 0);
    repeat (6) step();

    // reset mid-stream with entries buffered and a request in flight
    id_ready = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    check_eq("mid_rst_req", imem_req, 0);
    step();
    reset = 1'b0;
    id_ready = 1'b1;
    load_seq(0, 16);
    #1;
    check_eq("mid_rst_valid", id_valid, 0);
    check_eq("mid_rst_req1", imem_req, 1);
    check_eq("mid_rst_addr", imem_addr, 0);
    step();
    check_eq("mid_rst_n2_valid", id_valid, 0);
    step();
    check_eq("mid_rst_n3_valid", id_valid, 1);
    check_eq("mid_rst_n3_pc", id_pc, 0);
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cpu_fetch_unit.md
Name: cpu_fetch_unit

Overview:
- Instruction-fetch stage for the 19-bit pipelined CPU. Sits directly upstream of the decode stage.
- Owns the fetch PC and issues reads to the synchronous instruction memory (1024 x 19). Buffers returned instructions with their PCs in a small prefetch FIFO.
- Presents instructions to decode over a valid/ready handshake.
- Accepts redirects (JMP/BEQ/BNE/CALL/RET targets) from execute and flushes wrong-path work.

Parameters:
- IW, 19, instruction width.
- AW, 10, instruction address / PC width (1024-word memory).
- DEPTH, 4, prefetch FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  read request to instruction memory this cycle.
- imem_addr  out  AW  read address; always equals fetch PC.
- imem_rdata  in  IW  read data. Valid exactly one cycle after the cycle imem_req was high.
- redirect_valid  in  1  execute stage orders a PC change.
- redirect_addr  in  AW  new fetch PC.
- id_valid  out  1  head FIFO entry is available to decode.
- id_instr  out  IW  instruction at FIFO head.
- id_pc  out  AW  address of id_instr.
- id_ready  in  1  decode accepts the head this cycle.

Behaviour:
- Reset, sampled on clk edge while high:
  - fetch_pc=0, FIFO empty, inflight=0.
  - id_valid=0, id_instr=0, id_pc=0.
  - imem_req=0 combinationally for as long as reset is high.
- Outputs:
  - imem_req = !reset && !redirect_valid && (occupancy + inflight < DEPTH).
  - imem_addr = fetch_pc.
- On a cycle with imem_req=1:
  - fetch_pc <= fetch_pc+1, modulo 2^AW (1023 wraps to 0).
  - inflight <= 1. On a cycle without imem_req, inflight <= 0.
- Response handling: in the cycle after a request, imem_rdata plus the PC it was issued with (held in a register) is pushed into the FIFO at the clock edge. The entry becomes visible at the head no earlier than the following cycle; there is no bypass.
- Fetch latency: first request at cycle C, id_valid=1 with that instruction at C+2.
- Handshake:
  - A transfer occurs on any cycle with id_valid && id_ready; the head is popped.
  - While id_valid=1 and id_ready=0, id_instr and id_pc hold stable, except when a redirect occurs.
  - id_instr/id_pc are don't-care when id_valid=0 but must not produce X after reset.
- Throughput: with id_ready held high, one instruction per cycle in steady state.
- Credit rule: occupancy + inflight never exceeds DEPTH. The FIFO never overflows, and no returning response is ever dropped for lack of space.
- Redirect in cycle N:
  - imem_req=0 in N.
  - Any response arriving in N is discarded.
  - FIFO is flushed, occupancy <= 0.
  - fetch_pc <= redirect_addr.
  - Cycle N+1: imem_req=1, imem_addr=redirect_addr.
  - Cycle N+3: id_valid=1 with the target instruction.
- Redirect with a simultaneous transfer in N: the transfer completes (decode owns the head instruction). All other entries are flushed.
- Back-to-back redirects: the last one wins. Each resets the sequence above.
- Reset mid-operation: a reset cycle overrides redirect, push and pop. All state returns to reset values.
- FIFO pointers: log2(DEPTH) bits, wrapping. Occupancy has log2(DEPTH)+1 bits. Simultaneous push and pop leaves occupancy unchanged.

Test Plan:
- Sequential fetch: reset 2 cycles, memory[i]=i+0x100, id_ready=1 -> id_valid rises 2 cycles after reset release. id_pc=0,1,2,... with id_instr=0x100,0x101,... one per cycle, no gaps.
- Backpressure: id_ready=0 for 10 cycles after first valid -> exactly DEPTH=4 entries buffered, imem_req=0 once credit is exhausted, head held at pc 0. Releasing id_ready delivers pc 0..3 then continues at 4 with no loss or duplicate.
- Redirect: redirect_valid=1, redirect_addr=0x200 while FIFO holds pc 5..8 -> the response in the redirect cycle is dropped. Next cycle imem_addr=0x200; id_valid low for 2 cycles, then id_pc=0x200; pc 5..8 are never presented after the redirect.
- Redirect with transfer: id_valid=id_ready=1 at pc 7 in the same cycle as a redirect to 0x010 -> pc 7 is consumed once, next presented id_pc=0x010.
- Wrap-around: redirect to 0x3FE, id_ready=1 -> id_pc sequence 0x3FE,0x3FF,0x000,0x001.
- Reset mid-stream: assert reset for 1 cycle while FIFO holds 3 entries and a request is inflight -> id_valid=0 next cycle, fetch restarts at pc 0, no stale instruction appears.
